l1_ctrl: RTL and testbench

L1_CTRL -- requirements
Module: l1_ctrl

---
 rtl/l1_pkg.sv | 25 ++
 rtl/l1_tag_data_array.sv | 38 +++
 rtl/l1_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_l1_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/l1_pkg.sv
// Shared sizes, FSM state encoding and line layout for the L1 controller and L2 interface.
package l1_pkg;

    localparam int unsigned L1_LINES      = 16;
    localparam int unsigned L1_INDEX_SIZE = 4;
    localparam int unsigned L1_TAG_SIZE   = 26;
    localparam int unsigned L1_WORD_SIZE  = 32;
    localparam int unsigned L2_WORD_SIZE  = L1_WORD_SIZE;
    // L2 request is held long enough to straddle both phases of the 2-cycle L2 pipeline
    localparam int unsigned L2_WINDOW     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_L2_REQ,
        ST_RESP
    } l1_state_e;

    typedef struct packed {
        logic                     valid;
        logic [L1_TAG_SIZE-1:0]   tag;
        logic [L1_WORD_SIZE-1:0]  data;
    } l1_line_t;

endpackage

// File: rtl/l1_tag_data_array.sv
// Direct-mapped L1 storage: async read, sync single-port write, valid bits cleared on reset.
module l1_tag_data_array
    import l1_pkg::*;
#(
    parameter int unsigned LINES      = L1_LINES,
    parameter int unsigned INDEX_SIZE = L1_INDEX_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_SIZE-1:0] idx,
    output l1_line_t              rd_line,
    input  logic                  wr_en,
    input  l1_line_t              wr_line
);

    logic [LINES-1:0]        valid_q;
    logic [L1_TAG_SIZE-1:0]  tag_q  [LINES];
    logic [L1_WORD_SIZE-1:0] data_q [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[idx] <= wr_line.valid;
        end
    end

    // Tag/data need no reset: they are only observed through a valid bit
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx]  <= wr_line.tag;
            data_q[idx] <= wr_line.data;
        end
    end

    assign rd_line = {valid_q[idx], tag_q[idx], data_q[idx]};

endmodule

// File: rtl/l1_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 controller in front of a slow L2.
// Optional macro L1_STATS_EN adds saturating read hit/miss counters (hit_cnt, miss_cnt).
module l1_ctrl
    import l1_pkg::*;
#(
    parameter int unsigned LINES      = L1_LINES,
    parameter int unsigned INDEX_SIZE = L1_INDEX_SIZE,
    parameter int unsigned TAG_SIZE   = L1_TAG_SIZE,
    parameter int unsigned WORD_SIZE  = L1_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_wr,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_ready,
    output logic                 cpu_rvalid,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_hit,
    output logic [WORD_SIZE-1:0] l2_addr,
    output logic [WORD_SIZE-1:0] l2_wdata,
    output logic                 l2_wr_en,
    input  logic [WORD_SIZE-1:0] l2_rdata,
    input  logic                 l2_hit
`ifdef L1_STATS_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);

    l1_state_e              state;
    logic                   req_wr;
    logic [WORD_SIZE-1:0]   req_addr;
    logic [WORD_SIZE-1:0]   req_wdata;
    logic [1:0]             win_cnt;
    logic                   l2_hit_q;
    logic [L2_WORD_SIZE-1:0] l2_rdata_q;

    logic [INDEX_SIZE-1:0]  req_idx_c;
    logic [TAG_SIZE-1:0]    req_tag_c;
    l1_line_t               rd_line_c;
    l1_line_t               wr_line_c;
    logic                   wr_en_c;
    logic                   l1_hit_c;
    logic                   win_last_c;
    logic                   l2_hit_now_c;
    logic [WORD_SIZE-1:0]   l2_data_now_c;

    assign req_idx_c  = req_addr[INDEX_SIZE+1:2];
    assign req_tag_c  = req_addr[WORD_SIZE-1 -: TAG_SIZE];
    assign l1_hit_c   = rd_line_c.valid && (rd_line_c.tag == req_tag_c);
    assign win_last_c = (win_cnt == 2'(L2_WINDOW - 1));

    // Include the current window cycle so an ack on the last cycle still counts
    assign l2_hit_now_c  = l2_hit_q | l2_hit;
    assign l2_data_now_c = l2_hit ? l2_rdata : l2_rdata_q;

    // Array write: data update on write hit in LOOKUP, line fill on L2 read hit
    always_comb begin
        wr_en_c   = 1'b0;
        wr_line_c = '{valid: 1'b1, tag: req_tag_c, data: l2_data_now_c};
        if (state == ST_LOOKUP && req_wr && l1_hit_c) begin
            wr_en_c        = 1'b1;
            wr_line_c.data = req_wdata;
        end else if (state == ST_L2_REQ && win_last_c && !req_wr && l2_hit_now_c) begin
            wr_en_c = 1'b1;
        end
    end

    l1_tag_data_array #(
        .LINES      (LINES),
        .INDEX_SIZE (INDEX_SIZE)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .idx     (req_idx_c),
        .rd_line (rd_line_c),
        .wr_en   (wr_en_c),
        .wr_line (wr_line_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_wr     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            win_cnt    <= '0;
            l2_hit_q   <= 1'b0;
            l2_rdata_q <= '0;
            cpu_ready  <= 1'b1;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            cpu_hit    <= 1'b0;
            l2_addr    <= '0;
            l2_wdata   <= '0;
            l2_wr_en   <= 1'b0;
        end else begin
            cpu_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        req_wr    <= cpu_wr;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        cpu_ready <= 1'b0;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (!req_wr && l1_hit_c) begin
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= rd_line_c.data;
                        cpu_hit    <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        win_cnt    <= '0;
                        l2_hit_q   <= 1'b0;
                        l2_rdata_q <= '0;
                        l2_addr    <= req_addr;
                        l2_wr_en   <= req_wr;
                        l2_wdata   <= req_wr ? req_wdata : '0;
                        state      <= ST_L2_REQ;
                    end
                end
                ST_L2_REQ: begin
                    if (l2_hit) begin
                        l2_hit_q   <= 1'b1;
                        l2_rdata_q <= l2_rdata;
                    end
                    if (win_last_c) begin
                        l2_addr    <= '0;
                        l2_wdata   <= '0;
                        l2_wr_en   <= 1'b0;
                        cpu_rvalid <= 1'b1;
                        cpu_hit    <= l2_hit_now_c;
                        if (req_wr) begin
                            cpu_rdata <= req_wdata;
                        end else begin
                            cpu_rdata <= l2_hit_now_c ? l2_data_now_c : '0;
                        end
                        state <= ST_RESP;
                    end else begin
                        win_cnt <= win_cnt + 2'd1;
                    end
                end
                ST_RESP: begin
                    cpu_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    cpu_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef L1_STATS_EN
    // Read-only lookup statistics, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == ST_LOOKUP && !req_wr) begin
            if (l1_hit_c && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (!l1_hit_c && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_l1_ctrl.sv
// Directed plus randomized bench for l1_ctrl against a line-array reference model.
module tb_l1_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_hit;
    logic [31:0] l2_addr;
    logic [31:0] l2_wdata;
    logic        l2_wr_en;
    logic [31:0] l2_rdata;
    logic        l2_hit;

    int checks = 0;
    int errors = 0;

    // Reference model: one word per line, indexed by addr[5:2], tag addr[31:6]
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];

    always #5 clk = ~clk;

    l1_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_hit    (cpu_hit),
        .l2_addr    (l2_addr),
        .l2_wdata   (l2_wdata),
        .l2_wr_en   (l2_wr_en),
        .l2_rdata   (l2_rdata),
        .l2_hit     (l2_hit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU access. hit_cyc = window cycle (0..3) where L2 acks; >=4 means L2 never acks.
    task automatic access(input string name, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hit_cyc, input logic [31:0] l2d);
        int          idx;
        logic [25:0] tag;
        bit          l1hit, exp_l2, l2ack, seen;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        int          cyc, win, wr_cnt, addr_bad, wdata_bad, idle_bad;
        logic [31:0] held;

        idx   = int'(addr[5:2]);
        tag   = addr[31:6];
        l1hit = m_valid[idx] && (m_tag[idx] == tag);
        exp_l2 = wr || !l1hit;
        l2ack = (hit_cyc < 4);
        if (!wr && l1hit) begin
            exp_rdata = m_data[idx];
            exp_hit   = 1'b1;
        end else if (!wr) begin
            exp_rdata = l2ack ? l2d : 32'h0;
            exp_hit   = l2ack;
        end else begin
            exp_rdata = wdata;
            exp_hit   = l2ack;
        end

        @(negedge clk);
        check({name, " ready"}, 32'(cpu_ready), 32'd1);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
        cyc = 2; win = 0; wr_cnt = 0; addr_bad = 0; wdata_bad = 0; idle_bad = 0; seen = 0;
        while (cyc < 30) begin
            if (cpu_rvalid) begin
                seen = 1;
                break;
            end
            if (l2_wr_en || l2_addr != 32'h0) begin
                if (l2_addr != addr) addr_bad++;
                if (l2_wdata != (wr ? wdata : 32'h0)) wdata_bad++;
                if (l2_wr_en) wr_cnt++;
                l2_hit   = (win == hit_cyc);
                l2_rdata = (win == hit_cyc) ? l2d : 32'($urandom);
                win++;
            end else begin
                if (l2_wdata != 32'h0) idle_bad++;
                l2_hit   = 1'b0;
                l2_rdata = 32'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        l2_hit = 1'b0;
        check({name, " rvalid seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(cyc), exp_l2 ? 32'd7 : 32'd3);
        check({name, " l2 window"}, 32'(win), exp_l2 ? 32'd4 : 32'd0);
        check({name, " l2 wr_en cycles"}, 32'(wr_cnt), wr ? 32'd4 : 32'd0);
        check({name, " l2 addr/wdata"}, 32'(addr_bad + wdata_bad + idle_bad), 32'd0);
        check({name, " rdata"}, cpu_rdata, exp_rdata);
        check({name, " hit"}, 32'(cpu_hit), 32'(exp_hit));
        held = cpu_rdata;
        @(negedge clk);
        check({name, " rvalid pulse"}, 32'(cpu_rvalid), 32'd0);
        check({name, " rdata hold"}, cpu_rdata, held);

        if (wr && l1hit) m_data[idx] = wdata;
        if (!wr && !l1hit && l2ack) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_data[idx]  = l2d;
        end
    endtask

    initial begin
        int          bad;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        l2_rdata = '0; l2_hit = 1'b0;
        repeat (2) @(negedge clk);
        check("reset rvalid", 32'(cpu_rvalid), 32'd0);
        check("reset rdata", cpu_rdata, 32'h0);
        check("reset hit", 32'(cpu_hit), 32'd0);
        check("reset l2", l2_addr | l2_wdata | 32'(l2_wr_en), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ready after reset", 32'(cpu_ready), 32'd1);

        access("first read fill", 1'b0, 32'h0000_0040, 32'h0, 1, 32'hDEAD_BEEF);
        access("repeat read hit", 1'b0, 32'h0000_0040, 32'h0, 9, 32'h0);
        access("write hit", 1'b1, 32'h0000_0040, 32'h1234_5678, 2, 32'h0);
        access("read after write", 1'b0, 32'h0000_0040, 32'h0, 9, 32'h0);
        access("l2 miss read", 1'b0, 32'h0000_0080, 32'h0, 9, 32'h0);
        access("l2 miss reissue", 1'b0, 32'h0000_0080, 32'h0, 3, 32'hCAFE_0080);
        access("conflict read", 1'b0, 32'h0000_0440, 32'h0, 0, 32'hA5A5_0440);
        access("conflict reread", 1'b0, 32'h0000_0440, 32'h0, 9, 32'h0);
        access("write miss", 1'b1, 32'h0000_0044, 32'h7777_0044, 9, 32'h0);
        access("read after write miss", 1'b0, 32'h0000_0044, 32'h0, 0, 32'h0BAD_0044);

        // Reset in the middle of an L2 window aborts the request
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_0100; cpu_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        check("l2 active before abort", 32'(l2_addr), 32'h0000_0100);
        rst = 1'b1;
        @(negedge clk);
        check("abort l2 cleared", l2_addr | l2_wdata | 32'(l2_wr_en), 32'h0);
        check("abort ready", 32'(cpu_ready), 32'd1);
        rst = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (cpu_rvalid) bad++;
        end
        check("abort no rvalid", 32'(bad), 32'd0);
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        access("read after abort", 1'b0, 32'h0000_0040, 32'h0, 2, 32'h5555_0040);
        access("other line cleared", 1'b0, 32'h0000_0440, 32'h0, 1, 32'h6666_0440);

        // Randomized traffic over a small tag set to mix hits, misses and conflicts
        for (int n = 0; n < 40; n++) begin
            a = {26'(1 + $urandom_range(0, 2)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            access("random", 1'($urandom_range(0, 1)), a, 32'($urandom),
                   int'($urandom_range(0, 5)), 32'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
